// File: rtl/wind_gen.sv
// Per-turn wind generator: an LFSR step per next_turn rise, reduced to a signed
// target by restoring division, then a one-unit-per-tick ramp of the visible wind.
module wind_gen #(
    parameter int                LFSR_W   = 16,
    parameter logic [LFSR_W-1:0] SEED     = 16'hBEEF,
    parameter logic [LFSR_W-1:0] TAPS     = 16'hB400,
    parameter int                WIND_MAX = 50,
    parameter int                OUT_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    next_turn,
    input  logic                    tick,
    output logic signed [OUT_W-1:0] wind_out,
    output logic signed [OUT_W-1:0] wind_target,
    output logic                    busy,
    output logic                    valid
);

    localparam int M     = 2 * WIND_MAX + 1;
    localparam int REM_W = $clog2(M) + 1;
    localparam int CNT_W = $clog2(LFSR_W + 1);

    if (SEED == '0) begin : g_seed_check
        $error("wind_gen: SEED must be nonzero");
    end

    if (WIND_MAX < 1 || WIND_MAX > (2 ** (OUT_W - 1)) - 1) begin : g_width_check
        $error("wind_gen: OUT_W cannot hold +/-WIND_MAX");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, REDUCE, RAMP} state_t;

    state_t                    state_q, state_d;
    logic [LFSR_W-1:0]         lfsr_q;
    logic                      turn_prev_q;
    logic                      pending_q, pending_d;
    logic [LFSR_W-1:0]         div_q;
    logic [REM_W-1:0]          rem_q;
    logic [CNT_W-1:0]          cnt_q;
    logic signed [OUT_W-1:0]   wind_q, target_q;
    logic                      busy_q, valid_q;

    logic                      rise;
    logic [LFSR_W-1:0]         lfsr_step;
    logic [REM_W-1:0]          trial;
    logic                      trial_ge;

    always_comb begin
        rise      = next_turn & ~turn_prev_q;
        lfsr_step = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
        trial     = {rem_q[REM_W-2:0], div_q[LFSR_W-1]};
        trial_ge  = (trial >= REM_W'(M));
        state_d   = state_q;
        pending_d = pending_q | rise;
        case (state_q)
            IDLE: begin
                if (pending_q | rise) begin
                    state_d   = SHIFT;
                    // A fresh rise arriving while an older request is consumed stays queued
                    pending_d = pending_q & rise;
                end
            end
            SHIFT:   state_d = REDUCE;
            REDUCE:  if (cnt_q == CNT_W'(LFSR_W)) state_d = RAMP;
            RAMP:    if (wind_q == target_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // REDUCE runs LFSR_W division steps, then spends one cycle publishing the target
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED;
            turn_prev_q <= 1'b0;
            pending_q   <= 1'b0;
            div_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            wind_q      <= '0;
            target_q    <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b1;
        end else begin
            turn_prev_q <= next_turn;
            pending_q   <= pending_d;
            state_q     <= state_d;
            busy_q      <= (state_d != IDLE);
            valid_q     <= (state_d == IDLE) && !pending_d;
            case (state_q)
                SHIFT: begin
                    lfsr_q <= lfsr_step;
                    div_q  <= lfsr_step;
                    rem_q  <= '0;
                    cnt_q  <= '0;
                end
                REDUCE: begin
                    if (cnt_q == CNT_W'(LFSR_W)) begin
                        target_q <= OUT_W'(int'(rem_q) - WIND_MAX);
                    end else begin
                        rem_q <= trial_ge ? (trial - REM_W'(M)) : trial;
                        div_q <= {div_q[LFSR_W-2:0], trial_ge};
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RAMP: begin
                    if (tick && (wind_q != target_q)) begin
                        wind_q <= (wind_q < target_q) ? (wind_q + OUT_W'(1)) : (wind_q - OUT_W'(1));
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign wind_out    = wind_q;
    assign wind_target = target_q;
    assign busy        = busy_q;
    assign valid       = valid_q;

endmodule

// File: tb/tb_wind_gen.sv
// Directed-sequence bench for wind_gen with randomized tick spacing, checked
// against an arithmetic model of the LFSR, modulus and ramp.
module tb_wind_gen;

    localparam int LFSR_W   = 16;
    localparam int WIND_MAX = 50;
    localparam int OUT_W    = 8;
    localparam int MODULUS  = 2 * WIND_MAX + 1;
    localparam int SEED_INT = 48879;
    localparam int TAPS_INT = 46080;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    next_turn = 1'b0;
    logic                    tick = 1'b0;
    logic signed [OUT_W-1:0] wind_out;
    logic signed [OUT_W-1:0] wind_target;
    logic                    busy;
    logic                    valid;

    int checks = 0;
    int errors = 0;
    int cycleCount = 0;
    int mLfsr;
    int mWind;
    int mTarget;

    wind_gen #(
        .LFSR_W  (LFSR_W),
        .SEED    (16'hBEEF),
        .TAPS    (16'hB400),
        .WIND_MAX(WIND_MAX),
        .OUT_W   (OUT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .next_turn  (next_turn),
        .tick       (tick),
        .wind_out   (wind_out),
        .wind_target(wind_target),
        .busy       (busy),
        .valid      (valid)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached, observed running expected finished");
        $fatal(1, "[TB] timeout");
    end

    // Shift left, feedback bit = parity of the tapped state bits
    function automatic int lfsrAdvance(input int s);
        int fb;
        fb = 0;
        for (int i = 0; i < LFSR_W; i++) begin
            if (((TAPS_INT / (2 ** i)) % 2) == 1) fb = fb ^ ((s / (2 ** i)) % 2);
        end
        return ((s * 2) % (2 ** LFSR_W)) + fb;
    endfunction

    function automatic int targetOf(input int s);
        return (s % MODULUS) - WIND_MAX;
    endfunction

    task automatic checkOutput(input string tag, input logic signed [31:0] obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive inputs, then advance to 1 time unit after the next rising edge
    task automatic applyStimulus(input logic nt, input logic tk, input logic rn);
        next_turn = nt;
        tick      = tk;
        rst_n     = rn;
        @(posedge clk);
        #1;
        cycleCount++;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_wind"}, 32'(wind_out), 0);
        checkOutput({tag, "_target"}, 32'(wind_target), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_valid"}, 32'(valid), 1);
    endtask

    task automatic doReset();
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b0);
        mLfsr   = SEED_INT;
        mWind   = 0;
        mTarget = 0;
    endtask

    // Entered just after the edge E0 that took the request; target must appear at E0+18
    task automatic reduceCheck(input int oldTarget, input logic holdLevel);
        checkOutput("busy_after_E0", 32'(busy), 1);
        checkOutput("valid_after_E0", 32'(valid), 0);
        for (int k = 1; k <= 17; k++) begin
            applyStimulus(holdLevel, ($urandom_range(0, 1) == 1), 1'b1);
            if (k == 17) begin
                checkOutput("target_at_E17", 32'(wind_target), oldTarget);
                checkOutput("wind_during_reduce", 32'(wind_out), mWind);
            end
        end
        applyStimulus(holdLevel, 1'b0, 1'b1);
        checkOutput("target_at_E18", 32'(wind_target), mTarget);
        checkOutput("wind_at_E18", 32'(wind_out), mWind);
        checkOutput("busy_at_E18", 32'(busy), 1);
    endtask

    task automatic requestPulse(input logic holdLevel);
        int oldTarget;
        applyStimulus(1'b1, 1'b0, 1'b1);
        oldTarget = mTarget;
        mLfsr     = lfsrAdvance(mLfsr);
        mTarget   = targetOf(mLfsr);
        reduceCheck(oldTarget, holdLevel);
    endtask

    task automatic rampToTarget(input logic holdLevel, input int injectRises, input int expValidEnd,
                                input int maxGap);
        int   i;
        int   gap;
        logic nt;
        i = 0;
        while (mWind != mTarget) begin
            gap = $urandom_range(0, maxGap);
            for (int g = 0; g < gap; g++) begin
                applyStimulus(holdLevel, 1'b0, 1'b1);
                checkOutput("wind_hold_gap", 32'(wind_out), mWind);
            end
            nt = holdLevel | (injectRises > 0 && i > 0 && (i % 5) == 0 && (i / 5) <= injectRises);
            applyStimulus(nt, 1'b1, 1'b1);
            mWind = mWind + ((mTarget > mWind) ? 1 : -1);
            checkOutput("wind_step", 32'(wind_out), mWind);
            checkOutput("valid_in_ramp", 32'(valid), 0);
            i++;
        end
        applyStimulus(holdLevel, 1'b0, 1'b1);
        checkOutput("busy_after_ramp", 32'(busy), 0);
        checkOutput("valid_after_ramp", 32'(valid), expValidEnd);
        checkOutput("wind_final", 32'(wind_out), mTarget);
    endtask

    initial begin
        int startCycle;
        int oldTarget;

        $display("[TB] reset");
        doReset();
        checkResetState("reset");

        $display("[TB] first request");
        requestPulse(1'b0);
        rampToTarget(1'b0, 0, 1, 3);

        $display("[TB] second request");
        requestPulse(1'b0);
        rampToTarget(1'b0, 0, 1, 3);

        $display("[TB] held level");
        doReset();
        startCycle = cycleCount;
        requestPulse(1'b1);
        rampToTarget(1'b1, 0, 1, 1);
        while (cycleCount - startCycle < 200) applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("held_busy", 32'(busy), 0);
        checkOutput("held_valid", 32'(valid), 1);
        checkOutput("held_target", 32'(wind_target), mTarget);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("held_release_busy", 32'(busy), 0);

        $display("[TB] pending collapse");
        doReset();
        requestPulse(1'b0);
        rampToTarget(1'b0, 3, 0, 2);
        applyStimulus(1'b0, 1'b0, 1'b1);
        oldTarget = mTarget;
        mLfsr     = lfsrAdvance(mLfsr);
        mTarget   = targetOf(mLfsr);
        reduceCheck(oldTarget, 1'b0);
        rampToTarget(1'b0, 0, 1, 2);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("collapse_no_extra_busy", 32'(busy), 0);
        checkOutput("collapse_no_extra_target", 32'(wind_target), mTarget);

        $display("[TB] reset during reduce");
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        for (int k = 2; k <= 5; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            checkOutput("reduce_tick_ignored", 32'(wind_out), 0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        mLfsr   = SEED_INT;
        mWind   = 0;
        mTarget = 0;
        checkResetState("midreset");
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkResetState("midreset_release");
        requestPulse(1'b0);
        rampToTarget(1'b0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
